// File: rtl/avmm_arb_pkg.sv
// avmm_arb_pkg: shared state type and constants for the AVMM NoC arbiter
package avmm_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, ACK, RDWAIT} state_t;
  localparam int AVMM_ADDR_W = 20;
  localparam int AVMM_DATA_W = 32;
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin pick of the first eligible port after the last grant
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  elig,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] gnt,
  output logic          vld
);
  // Scan from the farthest candidate down so the nearest one after last wins
  always_comb begin
    gnt = '0;
    vld = 1'b0;
    for (int k = N; k >= 1; k--) begin
      if (elig[(int'(last) + k) % N]) begin
        gnt = IW'((int'(last) + k) % N);
        vld = 1'b1;
      end
    end
  end
endmodule

// File: rtl/avmm_noc_arbiter.sv
// avmm_noc_arbiter: round-robin share of one AVMM master among NUM_REQ regions, one transaction at a time.
// Optional watchdog enabled by defining AVMM_ARB_TIMEOUT_EN.
module avmm_noc_arbiter
  import avmm_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = AVMM_ADDR_W,
  parameter int DATA_W      = AVMM_DATA_W,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        freeze,
  input  logic [NUM_REQ*ADDR_W-1:0] s_address,
  input  logic [NUM_REQ*DATA_W-1:0] s_writedata,
  input  logic [NUM_REQ-1:0]        s_write,
  input  logic [NUM_REQ-1:0]        s_read,
  output logic [NUM_REQ-1:0]        s_waitrequest,
  output logic [DATA_W-1:0]         s_readdata,
  output logic [NUM_REQ-1:0]        s_readdatavalid,
  output logic [ADDR_W-1:0]         m_address,
  output logic [DATA_W-1:0]         m_writedata,
  output logic                      m_write,
  output logic                      m_read,
  input  logic                      m_waitrequest,
  input  logic [DATA_W-1:0]         m_readdata,
  input  logic                      m_readdatavalid,
  output logic [NUM_REQ-1:0]        err_timeout
);
  localparam int IW = $clog2(NUM_REQ);
  state_t st;
  logic [IW-1:0] ptr, pick;
  logic pick_vld, is_rd, rd_ok, ret, tmo_fire, tmo_ack, discard;
  logic [DATA_W-1:0] ret_data;

  rr_picker #(.N(NUM_REQ), .IW(IW)) u_pick (
    .elig((s_read | s_write) & ~freeze),
    .last(ptr),
    .gnt (pick),
    .vld (pick_vld)
  );

  assign rd_ok    = m_readdatavalid & ~discard;
  assign ret      = is_rd && ((st == ACK && (tmo_ack || rd_ok)) || (st == RDWAIT && (rd_ok || tmo_fire)));
  assign ret_data = (st == ACK && tmo_ack) || (st == RDWAIT && !rd_ok) ? DATA_W'(TIMEOUT_DATA) : m_readdata;

  always_comb begin
    s_waitrequest = '1;
    if (st == ACK && !freeze[ptr]) s_waitrequest[ptr] = 1'b0;
  end

`ifdef AVMM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt;
  logic [NUM_REQ-1:0] err_q;
  logic tmo_q, dis_q;
  assign tmo_fire    = cnt == CW'(TIMEOUT_CYC - 1) && ((st == ISSUE && m_waitrequest) || (st == RDWAIT && !rd_ok));
  assign tmo_ack     = tmo_q;
  assign discard     = dis_q;
  assign err_timeout = err_q;
  // Counter only ever leaves ISSUE/RDWAIT through a zeroing state, so it restarts on every entry
  always_ff @(posedge clk)
    if (!rst) begin
      cnt   <= '0;
      err_q <= '0;
      tmo_q <= 1'b0;
      dis_q <= 1'b0;
    end else begin
      cnt   <= (st == ISSUE || st == RDWAIT) ? cnt + 1'b1 : '0;
      tmo_q <= tmo_fire && st == ISSUE;
      dis_q <= (tmo_fire && st == RDWAIT) | (dis_q & ~m_readdatavalid);
      if (tmo_fire) err_q[ptr] <= 1'b1;
    end
`else
  assign tmo_fire    = 1'b0;
  assign tmo_ack     = 1'b0;
  assign discard     = 1'b0;
  assign err_timeout = '0;
`endif

  always_ff @(posedge clk)
    if (!rst) begin
      st              <= IDLE;
      ptr             <= IW'(NUM_REQ - 1);
      is_rd           <= 1'b0;
      m_read          <= 1'b0;
      m_write         <= 1'b0;
      m_address       <= '0;
      m_writedata     <= '0;
      s_readdata      <= '0;
      s_readdatavalid <= '0;
    end else begin
      s_readdatavalid <= '0;
      case (st)
        IDLE: if (pick_vld) begin
          st          <= ISSUE;
          ptr         <= pick;
          is_rd       <= s_read[pick];
          m_read      <= s_read[pick];
          m_write     <= ~s_read[pick];
          m_address   <= s_address[int'(pick)*ADDR_W +: ADDR_W];
          m_writedata <= s_writedata[int'(pick)*DATA_W +: DATA_W];
        end
        ISSUE: if (!m_waitrequest || tmo_fire) begin
          st      <= ACK;
          m_read  <= 1'b0;
          m_write <= 1'b0;
        end
        ACK:     st <= !is_rd || tmo_ack || rd_ok ? IDLE : RDWAIT;
        default: st <= rd_ok || tmo_fire ? IDLE : RDWAIT;
      endcase
      // A region frozen mid-read still lets the NoC finish, but never sees the data
      if (ret) begin
        s_readdata           <= ret_data;
        s_readdatavalid[ptr] <= ~freeze[ptr];
      end
    end
endmodule

// File: tb/tb_avmm_noc_arbiter.sv
// tb_avmm_noc_arbiter: directed vectors for avmm_noc_arbiter with a simple NoC responder and region monitor
module tb_avmm_noc_arbiter;
  localparam int N = 4, AW = 20, DW = 32;
  logic clk = 1'b0, rst = 1'b0;
  logic [N-1:0] freeze = '0, s_write = '0, s_read = '0, s_waitrequest, s_readdatavalid, err_timeout;
  logic [N*AW-1:0] s_address = '0;
  logic [N*DW-1:0] s_writedata = '0;
  logic [DW-1:0] s_readdata, m_writedata, m_readdata = '0;
  logic [AW-1:0] m_address;
  logic m_write, m_read, m_waitrequest = 1'b0, m_readdatavalid = 1'b0;

  always #5 clk = ~clk;

  avmm_noc_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst), .freeze(freeze),
    .s_address(s_address), .s_writedata(s_writedata), .s_write(s_write), .s_read(s_read),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
    .m_address(m_address), .m_writedata(m_writedata), .m_write(m_write), .m_read(m_read),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
    .err_timeout(err_timeout)
  );

  int vecs = 0, errs = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // NoC responder: fixed read latency after acceptance, plus an on-demand stray pulse
  int rd_lat = 0, kick = 0, kick_seen = 0, cd = 0;
  logic [DW-1:0] rdata = '0;
  initial forever begin
    @(negedge clk);
    m_readdatavalid = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        m_readdatavalid = 1'b1;
        m_readdata = rdata;
      end
    end
    if (kick != kick_seen) begin
      kick_seen = kick;
      m_readdatavalid = 1'b1;
      m_readdata = 32'h5757_5757;
    end
    if (m_read && !m_waitrequest && rd_lat > 0) begin
      cd = rd_lat;
      rdata = 32'hC0DE_0000 ^ {12'h0, m_address};
    end
  end

  // Region-side monitor of acks and returned data
  int ack_cnt[N], rdv_cnt[N], ack_q[$];
  logic [DW-1:0] rdv_dat[N];
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (s_waitrequest[i] === 1'b0) begin
        ack_cnt[i]++;
        ack_q.push_back(i);
      end
      if (s_readdatavalid[i] === 1'b1) begin
        rdv_cnt[i]++;
        rdv_dat[i] = s_readdata;
      end
    end
  end

  int seen[N], a0[N], r0[N];
  logic [N-1:0] keep = '0;
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (ack_cnt[i] != seen[i]) begin
        seen[i] = ack_cnt[i];
        if (!keep[i]) begin
          s_read[i] = 1'b0;
          s_write[i] = 1'b0;
        end
      end
  endtask
  task automatic snap();
    for (int i = 0; i < N; i++) begin
      a0[i] = ack_cnt[i];
      r0[i] = rdv_cnt[i];
    end
  endtask
  task automatic do_reset();
    s_read = '0; s_write = '0; freeze = '0; keep = '0; m_waitrequest = 1'b0;
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b, f0;
    // reset values
    rst = 1'b0;
    repeat (3) tick();
    chk("rst_waitreq", s_waitrequest, 4'hF);
    chk("rst_mread", m_read, 0);
    chk("rst_mwrite", m_write, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_rdv", s_readdatavalid, 0);
    chk("rst_maddr", m_address, 0);
    chk("rst_rdata", s_readdata, 0);
    rst = 1'b1;
    // single write from port 2, minimum turnaround
    s_address[2*AW +: AW] = 20'h00100;
    s_writedata[2*DW +: DW] = 32'hA5A5_0001;
    s_write[2] = 1'b1;
    tick();
    chk("wr_mwrite", m_write, 1);
    chk("wr_mread", m_read, 0);
    chk("wr_addr", m_address, 20'h00100);
    chk("wr_data", m_writedata, 32'hA5A5_0001);
    chk("wr_wait_c1", s_waitrequest, 4'hF);
    tick();
    chk("wr_wait_c2", s_waitrequest, 4'b1011);
    chk("wr_mwrite_c2", m_write, 0);
    tick();
    chk("wr_wait_c3", s_waitrequest, 4'hF);
    tick();
    chk("wr_noreissue", m_write, 0);
    chk("wr_acks", ack_cnt[2], 1);
    // three concurrent reads, latency 3
    do_reset();
    snap();
    b = ack_q.size();
    rd_lat = 3;
    s_address[0*AW +: AW] = 20'h00010;
    s_address[1*AW +: AW] = 20'h00020;
    s_address[3*AW +: AW] = 20'h00030;
    s_read = 4'b1011;
    for (int t = 0; t < 80 && (rdv_cnt[0] - r0[0]) + (rdv_cnt[1] - r0[1]) + (rdv_cnt[3] - r0[3]) < 3; t++) tick();
    repeat (4) tick();
    chk("rd_nacks", ack_q.size() - b, 3);
    chk("rd_order0", ack_q[b], 0);
    chk("rd_order1", ack_q[b+1], 1);
    chk("rd_order2", ack_q[b+2], 3);
    chk("rd_rdv0", rdv_cnt[0] - r0[0], 1);
    chk("rd_rdv1", rdv_cnt[1] - r0[1], 1);
    chk("rd_rdv2", rdv_cnt[2] - r0[2], 0);
    chk("rd_rdv3", rdv_cnt[3] - r0[3], 1);
    chk("rd_dat0", rdv_dat[0], 32'hC0DE_0010);
    chk("rd_dat1", rdv_dat[1], 32'hC0DE_0020);
    chk("rd_dat3", rdv_dat[3], 32'hC0DE_0030);
    // write stalled by m_waitrequest for 5 cycles
    snap();
    s_address[1*AW +: AW] = 20'h0ABCD;
    s_writedata[1*DW +: DW] = 32'h1234_5678;
    m_waitrequest = 1'b1;
    s_write[1] = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall_wr%0d", k), m_write, 1);
      chk($sformatf("stall_addr%0d", k), m_address, 20'h0ABCD);
      chk($sformatf("stall_data%0d", k), m_writedata, 32'h1234_5678);
      chk($sformatf("stall_wait%0d", k), s_waitrequest, 4'hF);
      tick();
    end
    chk("stall_wr5", m_write, 1);
    m_waitrequest = 1'b0;
    tick();
    chk("stall_ack", s_waitrequest, 4'b1101);
    chk("stall_mwrite", m_write, 0);
    repeat (3) tick();
    chk("stall_nacks", ack_cnt[1] - a0[1], 1);
    // frozen port 0, port 1 served repeatedly
    do_reset();
    f0 = ack_cnt[0];
    snap();
    freeze[0] = 1'b1; s_read[0] = 1'b1; keep[0] = 1'b1;
    s_address[1*AW +: AW] = 20'h00055;
    s_write[1] = 1'b1; keep[1] = 1'b1;
    repeat (20) tick();
    chk("frz_served", (ack_cnt[1] - a0[1]) >= 3, 1);
    chk("frz_p0_acks", ack_cnt[0] - f0, 0);
    s_write[1] = 1'b0; keep[1] = 1'b0;
    repeat (6) tick();
    snap();
    rd_lat = 6;
    s_read[1] = 1'b1;
    repeat (3) tick();
    chk("frz_rd_ack", ack_cnt[1] - a0[1], 1);
    freeze[1] = 1'b1;
    repeat (10) tick();
    chk("frz_rdv_supp", rdv_cnt[1] - r0[1], 0);
    chk("frz_idle", s_waitrequest, 4'hF);
    freeze[1] = 1'b0;
    rd_lat = 1;
    snap();
    s_read[1] = 1'b1;
    for (int t = 0; t < 20 && rdv_cnt[1] == r0[1]; t++) tick();
    chk("frz_recover", rdv_cnt[1] - r0[1], 1);
    chk("frz_rec_dat", rdv_dat[1], 32'hC0DE_0055);
    chk("frz_p0_never", ack_cnt[0] - f0, 0);
`ifdef AVMM_ARB_TIMEOUT_EN
    // read with no response times out after 16 RDWAIT cycles
    do_reset();
    snap();
    rd_lat = 0;
    s_address[2*AW +: AW] = 20'h00200;
    s_read[2] = 1'b1;
    repeat (3) tick();
    repeat (15) tick();
    chk("tmo_early", rdv_cnt[2] - r0[2], 0);
    chk("tmo_err_early", err_timeout, 0);
    tick();
    chk("tmo_rdv", s_readdatavalid, 4'b0100);
    chk("tmo_data", s_readdata, 32'hDEAD_BEEF);
    chk("tmo_err", err_timeout, 4'b0100);
    // late stray response must be dropped, the next real one delivered
    snap();
    rd_lat = 5;
    s_read[2] = 1'b1;
    repeat (3) tick();
    kick++;
    repeat (8) tick();
    chk("tmo_late_cnt", rdv_cnt[2] - r0[2], 1);
    chk("tmo_late_dat", rdv_dat[2], 32'hC0DE_0200);
    chk("tmo_err_sticky", err_timeout, 4'b0100);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
